// File: rtl/wb_regfile.sv
// wb_regfile: writeback-stage register file. It selects the writeback value,
// commits it to the register array, serves two read ports and counts commits.
// Ports: i_clk, i_rst_n (async, active-low); i_RegWrite, i_MemtoReg,
//   i_readData, i_ALUresult, i_writeReg (writeback side);
//   i_readReg1/2 -> o_readData1/2 (combinational reads);
//   o_wbData (selected writeback value); o_wbCount (registered commit count).
// Option: define WB_REGFILE_BYPASS_EN for a same-cycle write-to-read bypass.
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_RegWrite,
  input  logic              i_MemtoReg,
  input  logic [DATA_W-1:0] i_readData,
  input  logic [DATA_W-1:0] i_ALUresult,
  input  logic [4:0]        i_writeReg,
  input  logic [4:0]        i_readReg1,
  input  logic [4:0]        i_readReg2,
  output logic [DATA_W-1:0] o_readData1,
  output logic [DATA_W-1:0] o_readData2,
  output logic [DATA_W-1:0] o_wbData,
  output logic [31:0]       o_wbCount
);

  logic [DATA_W-1:0] r_rf [NREGS];
  logic [31:0]       r_wbCount;
  logic              w_commit;
  logic [DATA_W-1:0] w_arr1;
  logic [DATA_W-1:0] w_arr2;

  assign o_wbData = i_MemtoReg ? i_readData : i_ALUresult;
  // $0 writes are dropped here, so they neither land nor count.
  assign w_commit = i_RegWrite && (i_writeReg != 5'd0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        r_rf[i] <= '0;
      end
      r_wbCount <= '0;
    end else if (w_commit) begin
      r_rf[i_writeReg] <= o_wbData;
      r_wbCount        <= r_wbCount + 32'd1;
    end
  end

  assign o_wbCount = r_wbCount;

  assign w_arr1 = (i_readReg1 == 5'd0) ? '0 : r_rf[i_readReg1];
  assign w_arr2 = (i_readReg2 == 5'd0) ? '0 : r_rf[i_readReg2];

`ifdef WB_REGFILE_BYPASS_EN
  // w_commit already excludes $0, so a bypass never shows a value on $0.
  always_comb begin
    o_readData1 = w_arr1;
    o_readData2 = w_arr2;
    if (w_commit && (i_readReg1 == i_writeReg)) begin
      o_readData1 = o_wbData;
    end
    if (w_commit && (i_readReg2 == i_writeReg)) begin
      o_readData2 = o_wbData;
    end
  end
`else
  assign o_readData1 = w_arr1;
  assign o_readData2 = w_arr2;
`endif

endmodule
